// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU sharing arbiter.
package alu_arb_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ALU_ILLEGAL = 32'hDEADBEEF;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR/XOR, illegal opcodes return ALU_ILLEGAL.
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y
);

  always_comb begin
    y = ALU_ILLEGAL;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ALU_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters with round-robin grant and a tagged response.
// Optional resp_err output is enabled by defining ALU_ARB_ERR_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally, operands captured
// EXEC  | ALU evaluates captured operands; result and id registered
// RESP  | response presented until resp_ready
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_y,
  output logic              busy
`ifdef ALU_ARB_ERR_EN
  ,
  output logic              resp_err
`endif
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    resp_y_q, resp_y_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [31:0]     alu_y;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    resp_y_d  = resp_y_q;
    resp_id_d = resp_id_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = EXEC;
          a_d     = req_a[32*gnt_idx +: 32];
          b_d     = req_b[32*gnt_idx +: 32];
          op_d    = req_op[3*gnt_idx +: 3];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end
      end
      EXEC: begin
        state_d   = RESP;
        resp_y_d  = alu_y;
        resp_id_d = id_q;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      id_q      <= '0;
      resp_y_q  <= '0;
      resp_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      id_q      <= id_d;
      resp_y_q  <= resp_y_d;
      resp_id_q <= resp_id_d;
    end
  end

`ifdef ALU_ARB_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == EXEC) err_d = (op_q > 3'b100);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign resp_err = err_q;
`endif

  // Gate with rst_n so no grant leaks out while reset is held.
  assign req_ready  = (state_q == IDLE && rst_n) ? gnt : '0;
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_y     = resp_y_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic vs. a reference model.
module tb_alu_share_arb;
  localparam int NREQ = 4;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic [31:0]      resp_y;
  logic             busy;
`ifdef ALU_ARB_ERR_EN
  logic             resp_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int ref_ptr  = 0;

  alu_share_arb #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
`ifdef ALU_ARB_ERR_EN
    ,
    .resp_err   (resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ref_ptr + k) % NREQ]) return (ref_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++)
      set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic txn(input logic [NREQ-1:0] mask, input int stall);
    int          g;
    logic [31:0] ey;
    logic [2:0]  eop;
    req_valid  = mask;
    resp_ready = 1'b0;
    #1;
    if (mask == '0) begin
      chk("idle_ready", req_ready, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      return;
    end
    g   = ref_grant(mask);
    eop = req_op[3*g +: 3];
    ey  = ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], eop);
    chk("grant", req_ready, 64'(1 << g));
    chk("idle_busy", busy, 0);
    ref_ptr = (g + 1) % NREQ;
    @(negedge clk);
    req_valid = NREQ'($urandom_range(0, 15));
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_valid", resp_valid, 0);
    @(negedge clk);
    #1;
    for (int s = 0; s <= stall; s++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_y", resp_y, ey);
      chk("resp_id", resp_id, 64'(g));
      chk("resp_ready_zero", req_ready, 0);
`ifdef ALU_ARB_ERR_EN
      chk("resp_err", resp_err, 64'(eop > 3'd4));
`endif
      if (s < stall) begin
        @(negedge clk);
        req_valid = NREQ'($urandom_range(0, 15));
        #1;
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = '0;
    #1;
    chk("back_idle_valid", resp_valid, 0);
    chk("back_idle_busy", busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", resp_y, 0);
    chk("rst_id", resp_id, 0);
`ifdef ALU_ARB_ERR_EN
    chk("rst_err", resp_err, 0);
`endif
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0;

    // Single requester 2: 5 + 7
    set_req(2, 32'd5, 32'd7, 3'b000);
    txn(4'b0100, 0);

    // All valid: grant order follows the pointer round
    randomize_ops();
    for (int n = 0; n < 5; n++) txn(4'b1111, 0);

    // SUB wrap and XOR pattern
    set_req(1, 32'd0, 32'd1, 3'b001);
    txn(4'b0010, 0);
    set_req(3, 32'hFFFF0000, 32'h0F0F0F0F, 3'b100);
    txn(4'b1000, 0);

    // Response back-pressure
    set_req(0, 32'h1234, 32'h00FF, 3'b010);
    txn(4'b0001, 5);

    // Illegal opcode
    set_req(2, 32'h1, 32'h2, 3'b110);
    txn(4'b0100, 1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      randomize_ops();
      txn(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // Reset in EXEC with the pointer away from zero
    txn(4'b0010, 0);
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_grant", req_ready, 64'(1 << ref_grant(4'b0100)));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    ref_ptr = 0;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_resp", resp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    randomize_ops();
    txn(4'b1111, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
